eth_tx_frame_arbiter: RTL and testbench

- Frame-level arbiter sharing the single 8-bit Ethernet TX AXI-Stream (tx_axis_*) between two sources.
- Source 0: command-decoder response frames. Source 1: ADC/radar data frames.
- Grants whole frames only, never interleaves bytes, and inserts a programmable inter-frame gap.
- Recovers from a stalled source by truncating the frame with an error flag.
- Sits between cmd_decoder_top's response path / ADC packetizer and the MAC TX FIFO, in the gtx_clk_bufg domain.

---
 rtl/eth_tx_arb_pkg.sv | 28 ++
 rtl/eth_tx_frame_arbiter_if.sv | 16 +
 rtl/eth_tx_arb_rr.sv | 25 ++
 rtl/eth_tx_frame_arbiter.sv | 211 +++++++++++++++++++++
 tb/tb_eth_tx_frame_arbiter.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/eth_tx_arb_pkg.sv
// Shared definitions for the Ethernet TX frame arbiter.
// Holds the FSM state encoding, the one-hot grant codes and the byte
// emitted on the truncation beat of an aborted frame.
package eth_tx_arb_pkg;

    localparam int AXIS_DATA_W = 8;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_PASS  = 3'd1;
    localparam logic [2:0] ST_ABORT = 3'd2;
    localparam logic [2:0] ST_DRAIN = 3'd3;
    localparam logic [2:0] ST_GAP   = 3'd4;

    typedef enum logic [2:0] {
        IDLE  = ST_IDLE,
        PASS  = ST_PASS,
        ABORT = ST_ABORT,
        DRAIN = ST_DRAIN,
        GAP   = ST_GAP
    } arb_state_e;

    localparam logic [1:0] GRANT_NONE = 2'b00;
    localparam logic [1:0] GRANT_S0   = 2'b01;
    localparam logic [1:0] GRANT_S1   = 2'b10;

    localparam logic [AXIS_DATA_W-1:0] ABORT_FILL_BYTE = 8'h00;

endpackage

// File: rtl/eth_tx_frame_arbiter_if.sv
// Byte-wide AXI-Stream bundle used for both arbiter inputs and the MAC TX output.
//   tdata/tvalid/tlast : driven by the master
//   tready             : driven by the slave
// tuser is carried as a separate port on the arbiter since only the TX side uses it.
interface eth_tx_frame_arbiter_if;
    import eth_tx_arb_pkg::*;

    logic [AXIS_DATA_W-1:0] tdata;
    logic                   tvalid;
    logic                   tlast;
    logic                   tready;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);

endinterface

// File: rtl/eth_tx_arb_rr.sv
// Two-way frame picker.
//   priority_mode : 1 = source 0 always wins a contention, 0 = round-robin
//   valid         : {s1_tvalid, s0_tvalid}
//   rr_ptr        : source favoured on the next contention in round-robin mode
//   pick          : one-hot choice (GRANT_S0 / GRANT_S1 / GRANT_NONE)
module eth_tx_arb_rr
    import eth_tx_arb_pkg::*;
(
    input  logic       priority_mode,
    input  logic [1:0] valid,
    input  logic       rr_ptr,
    output logic [1:0] pick
);

    always_comb begin
        pick = GRANT_NONE;
        case (valid)
            2'b01:   pick = GRANT_S0;
            2'b10:   pick = GRANT_S1;
            2'b11:   pick = (priority_mode || !rr_ptr) ? GRANT_S0 : GRANT_S1;
            default: pick = GRANT_NONE;
        endcase
    end

endmodule

// File: rtl/eth_tx_frame_arbiter.sv
// Frame-level arbiter sharing the MAC TX AXI-Stream between the command
// response path (s0) and the ADC data packetizer (s1). Whole frames are
// granted, a programmable inter-frame gap follows every frame, and a source
// that stalls mid-frame is cut off with a tuser-flagged tlast beat, after
// which its remaining bytes are swallowed up to its own tlast.
//
// Ports:
//   gtx_clk_bufg   : clock for all logic
//   gtx_resetn     : asynchronous active-low reset (released synchronously)
//   s0_axis        : command-response frames (slave)
//   s1_axis        : ADC frames (slave)
//   tx_axis        : towards the MAC TX FIFO (master)
//   tx_axis_tuser  : 1 on the tlast beat of a truncated frame
//   grant          : registered one-hot owner, 01 = s0, 10 = s1, 00 = none
//   frame_cnt0/1   : completed frames per source (wrapping)
//   abort_cnt      : truncated frames, both sources (wrapping)
module eth_tx_frame_arbiter
    import eth_tx_arb_pkg::*;
#(
    parameter int PRIORITY_MODE = 1,
    parameter int IFG_CYCLES    = 12,
    parameter int STALL_TIMEOUT = 1024,
    parameter int CNT_W         = 16
) (
    input  logic                   gtx_clk_bufg,
    input  logic                   gtx_resetn,
    eth_tx_frame_arbiter_if.slave  s0_axis,
    eth_tx_frame_arbiter_if.slave  s1_axis,
    eth_tx_frame_arbiter_if.master tx_axis,
    output logic                   tx_axis_tuser,
    output logic [1:0]             grant,
    output logic [CNT_W-1:0]       frame_cnt0,
    output logic [CNT_W-1:0]       frame_cnt1,
    output logic [CNT_W-1:0]       abort_cnt
);

    localparam int STALL_W = (STALL_TIMEOUT > 2) ? $clog2(STALL_TIMEOUT) : 1;
    localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(STALL_TIMEOUT - 1);
    localparam int GAP_W = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((IFG_CYCLES > 0) ? IFG_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Reset is asserted asynchronously but released two clocks later so
    // that every flop leaves reset on the same edge.
    logic [1:0] rst_sync_reg;
    logic       rst_n_int;

    always_ff @(posedge gtx_clk_bufg or negedge gtx_resetn) begin
        if (!gtx_resetn) begin
            rst_sync_reg <= 2'b00;
        end else begin
            rst_sync_reg <= {rst_sync_reg[0], 1'b1};
        end
    end

    assign rst_n_int = rst_sync_reg[1];

    arb_state_e             state_reg, state_next;
    logic [1:0]             grant_reg, grant_next;
    logic                   rr_ptr_reg, rr_ptr_next;
    logic [STALL_W-1:0]     stall_cnt_reg, stall_cnt_next;
    logic [GAP_W-1:0]       gap_cnt_reg, gap_cnt_next;
    logic [CNT_W-1:0]       frame_cnt0_reg, frame_cnt0_next;
    logic [CNT_W-1:0]       frame_cnt1_reg, frame_cnt1_next;
    logic [CNT_W-1:0]       abort_cnt_reg, abort_cnt_next;

    logic [1:0]             pick;
    logic                   sel_s1;
    logic [AXIS_DATA_W-1:0] g_tdata;
    logic                   g_tvalid;
    logic                   g_tlast;
    logic                   g_ready;
    logic [AXIS_DATA_W-1:0] tx_tdata;
    logic                   tx_tvalid;
    logic                   tx_tlast;
    logic                   tx_tuser;

    eth_tx_arb_rr u_rr (
        .priority_mode (PRIORITY_MODE != 0),
        .valid         ({s1_axis.tvalid, s0_axis.tvalid}),
        .rr_ptr        (rr_ptr_reg),
        .pick          (pick)
    );

    // Mux of the currently granted source.
    assign sel_s1   = grant_reg[1];
    assign g_tdata  = sel_s1 ? s1_axis.tdata  : s0_axis.tdata;
    assign g_tvalid = sel_s1 ? s1_axis.tvalid : s0_axis.tvalid;
    assign g_tlast  = sel_s1 ? s1_axis.tlast  : s0_axis.tlast;

    always_ff @(posedge gtx_clk_bufg or negedge rst_n_int) begin
        if (!rst_n_int) begin
            state_reg      <= IDLE;
            grant_reg      <= GRANT_NONE;
            rr_ptr_reg     <= 1'b0;
            stall_cnt_reg  <= '0;
            gap_cnt_reg    <= '0;
            frame_cnt0_reg <= '0;
            frame_cnt1_reg <= '0;
            abort_cnt_reg  <= '0;
        end else begin
            state_reg      <= state_next;
            grant_reg      <= grant_next;
            rr_ptr_reg     <= rr_ptr_next;
            stall_cnt_reg  <= stall_cnt_next;
            gap_cnt_reg    <= gap_cnt_next;
            frame_cnt0_reg <= frame_cnt0_next;
            frame_cnt1_reg <= frame_cnt1_next;
            abort_cnt_reg  <= abort_cnt_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        grant_next      = grant_reg;
        rr_ptr_next     = rr_ptr_reg;
        stall_cnt_next  = stall_cnt_reg;
        gap_cnt_next    = gap_cnt_reg;
        frame_cnt0_next = frame_cnt0_reg;
        frame_cnt1_next = frame_cnt1_reg;
        abort_cnt_next  = abort_cnt_reg;
        tx_tdata        = '0;
        tx_tvalid       = 1'b0;
        tx_tlast        = 1'b0;
        tx_tuser        = 1'b0;
        g_ready         = 1'b0;

        case (state_reg)
            IDLE: begin
                if (pick != GRANT_NONE) begin
                    grant_next     = pick;
                    // Favour the other source on the next contention.
                    rr_ptr_next    = pick[0];
                    stall_cnt_next = '0;
                    state_next     = PASS;
                end
            end

            PASS: begin
                tx_tdata  = g_tdata;
                tx_tvalid = g_tvalid;
                tx_tlast  = g_tlast;
                g_ready   = tx_axis.tready;
                // A completing handshake takes precedence over the timeout.
                if (g_tvalid && tx_axis.tready && g_tlast) begin
                    if (sel_s1) begin
                        frame_cnt1_next = frame_cnt1_reg + CNT_ONE;
                    end else begin
                        frame_cnt0_next = frame_cnt0_reg + CNT_ONE;
                    end
                    grant_next   = GRANT_NONE;
                    gap_cnt_next = '0;
                    state_next   = (IFG_CYCLES == 0) ? IDLE : GAP;
                end else if (g_tvalid) begin
                    // MAC backpressure alone never counts as a stall.
                    stall_cnt_next = '0;
                end else if (stall_cnt_reg == STALL_LAST) begin
                    state_next = ABORT;
                end else begin
                    stall_cnt_next = stall_cnt_reg + 1'b1;
                end
            end

            ABORT: begin
                tx_tdata  = ABORT_FILL_BYTE;
                tx_tvalid = 1'b1;
                tx_tlast  = 1'b1;
                tx_tuser  = 1'b1;
                if (tx_axis.tready) begin
                    abort_cnt_next = abort_cnt_reg + CNT_ONE;
                    state_next     = DRAIN;
                end
            end

            DRAIN: begin
                // Swallow the rest of the truncated frame.
                g_ready = 1'b1;
                if (g_tvalid && g_tlast) begin
                    grant_next   = GRANT_NONE;
                    gap_cnt_next = '0;
                    state_next   = (IFG_CYCLES == 0) ? IDLE : GAP;
                end
            end

            GAP: begin
                if (gap_cnt_reg == GAP_LAST) begin
                    state_next = IDLE;
                end else begin
                    gap_cnt_next = gap_cnt_reg + 1'b1;
                end
            end

            default: begin
                state_next = IDLE;
                grant_next = GRANT_NONE;
            end
        endcase
    end

    assign s0_axis.tready = g_ready && (grant_reg == GRANT_S0);
    assign s1_axis.tready = g_ready && (grant_reg == GRANT_S1);
    assign tx_axis.tdata  = tx_tdata;
    assign tx_axis.tvalid = tx_tvalid;
    assign tx_axis.tlast  = tx_tlast;
    assign tx_axis_tuser  = tx_tuser;
    assign grant          = grant_reg;
    assign frame_cnt0     = frame_cnt0_reg;
    assign frame_cnt1     = frame_cnt1_reg;
    assign abort_cnt      = abort_cnt_reg;

endmodule

// File: tb/tb_eth_tx_frame_arbiter.sv
// Directed bench for eth_tx_frame_arbiter.
// dut_a: strict priority, IFG 12, stall timeout 1024, 4-bit counters.
// dut_b: round-robin, IFG 0, used for the alternating-grant check.
module tb_eth_tx_frame_arbiter;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    eth_tx_frame_arbiter_if a_s0 ();
    eth_tx_frame_arbiter_if a_s1 ();
    eth_tx_frame_arbiter_if a_tx ();
    eth_tx_frame_arbiter_if b_s0 ();
    eth_tx_frame_arbiter_if b_s1 ();
    eth_tx_frame_arbiter_if b_tx ();

    logic        a_tuser, b_tuser;
    logic [1:0]  a_grant, b_grant;
    logic [3:0]  a_fc0, a_fc1, a_ab;
    logic [15:0] b_fc0, b_fc1, b_ab;

    eth_tx_frame_arbiter #(.PRIORITY_MODE(1), .IFG_CYCLES(12), .STALL_TIMEOUT(1024), .CNT_W(4)) dut_a (
        .gtx_clk_bufg (clk),
        .gtx_resetn   (rst_n),
        .s0_axis      (a_s0),
        .s1_axis      (a_s1),
        .tx_axis      (a_tx),
        .tx_axis_tuser(a_tuser),
        .grant        (a_grant),
        .frame_cnt0   (a_fc0),
        .frame_cnt1   (a_fc1),
        .abort_cnt    (a_ab)
    );

    eth_tx_frame_arbiter #(.PRIORITY_MODE(0), .IFG_CYCLES(0), .STALL_TIMEOUT(16), .CNT_W(16)) dut_b (
        .gtx_clk_bufg (clk),
        .gtx_resetn   (rst_n),
        .s0_axis      (b_s0),
        .s1_axis      (b_s1),
        .tx_axis      (b_tx),
        .tx_axis_tuser(b_tuser),
        .grant        (b_grant),
        .frame_cnt0   (b_fc0),
        .frame_cnt1   (b_fc1),
        .abort_cnt    (b_ab)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // Source models: 0 = a_s0, 1 = a_s1, 2 = b_s0, 3 = b_s1.
    int         frames_left[4];
    int         len[4];
    int         idx[4];
    int         pause_at[4];
    int         pause_len[4];
    logic [7:0] seed[4];
    logic       hs[4];
    int         bp_mode;

    logic [7:0] mon_data[$];
    logic       mon_last[$];
    logic       mon_user[$];
    logic [1:0] mon_grant[$];
    logic [1:0] ord_a[$];
    logic [1:0] ord_b[$];
    int         last_q[$];
    int         rise_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic src_vld(input int n);
        return (frames_left[n] > 0) && !((idx[n] == pause_at[n]) && (pause_len[n] > 0));
    endfunction

    task automatic drive_sources();
        a_s0.tvalid = src_vld(0); a_s0.tdata = seed[0] + 8'(idx[0]); a_s0.tlast = (idx[0] == len[0] - 1);
        a_s1.tvalid = src_vld(1); a_s1.tdata = seed[1] + 8'(idx[1]); a_s1.tlast = (idx[1] == len[1] - 1);
        b_s0.tvalid = src_vld(2); b_s0.tdata = seed[2] + 8'(idx[2]); b_s0.tlast = (idx[2] == len[2] - 1);
        b_s1.tvalid = src_vld(3); b_s1.tdata = seed[3] + 8'(idx[3]); b_s1.tlast = (idx[3] == len[3] - 1);
        a_tx.tready = (bp_mode == 0) ? 1'b1 :
                      (bp_mode == 1) ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b0;
        b_tx.tready = 1'b1;
    endtask

    // Engine: sample at negedge, advance source models just after posedge.
    initial begin
        logic       prev_stall;
        logic [7:0] prev_data;
        logic       prev_last;
        logic [1:0] prev_grant;
        prev_stall = 1'b0; prev_data = 8'h00; prev_last = 1'b0; prev_grant = 2'b00;
        for (int n = 0; n < 4; n++) begin
            frames_left[n] = 0; len[n] = 1; idx[n] = 0; pause_at[n] = -1;
            pause_len[n] = 0; seed[n] = 8'h00; hs[n] = 1'b0;
        end
        bp_mode = 0;
        drive_sources();
        forever begin
            @(negedge clk);
            hs[0] = a_s0.tvalid & a_s0.tready;
            hs[1] = a_s1.tvalid & a_s1.tready;
            hs[2] = b_s0.tvalid & b_s0.tready;
            hs[3] = b_s1.tvalid & b_s1.tready;
            if (rst_n) begin
                if (prev_stall)
                    chk("tx_hold", {a_tx.tvalid, a_tx.tlast, a_tx.tdata}, {1'b1, prev_last, prev_data});
                if (a_tx.tvalid && a_tx.tready) begin
                    mon_data.push_back(a_tx.tdata);
                    mon_last.push_back(a_tx.tlast);
                    mon_user.push_back(a_tuser);
                    mon_grant.push_back(a_grant);
                    if (a_tx.tlast) begin
                        ord_a.push_back(a_grant);
                        last_q.push_back(cyc);
                    end
                end
                if (a_grant != 2'b00 && prev_grant == 2'b00) rise_q.push_back(cyc);
                if (b_tx.tvalid && b_tx.tready && b_tx.tlast) ord_b.push_back(b_grant);
            end
            prev_stall = rst_n && a_tx.tvalid && !a_tx.tready;
            prev_data  = a_tx.tdata;
            prev_last  = a_tx.tlast;
            prev_grant = a_grant;
            @(posedge clk);
            cyc++;
            #1;
            for (int n = 0; n < 4; n++) begin
                if (!rst_n) begin
                    frames_left[n] = 0; idx[n] = 0; pause_len[n] = 0;
                end else if (hs[n]) begin
                    if (idx[n] == len[n] - 1) begin
                        idx[n] = 0;
                        frames_left[n]--;
                        seed[n] = seed[n] + 8'h40;
                    end else begin
                        idx[n]++;
                    end
                end else if (frames_left[n] > 0 && idx[n] == pause_at[n] && pause_len[n] > 0) begin
                    pause_len[n]--;
                end
            end
            drive_sources();
        end
    end

    task automatic wait_done(input string tag, input int max_cyc);
        int c;
        c = 0;
        while ((frames_left[0] + frames_left[1] + frames_left[2] + frames_left[3]) != 0 && c < max_cyc) begin
            @(negedge clk);
            c++;
        end
        chk(tag, (c < max_cyc), 1'b1);
        repeat (20) @(negedge clk);
    endtask

    task automatic clear_mon();
        mon_data.delete(); mon_last.delete(); mon_user.delete(); mon_grant.delete();
        ord_a.delete(); ord_b.delete(); last_q.delete(); rise_q.delete();
    endtask

    task automatic chk_beat(input string tag, input int i, input logic [1:0] g, input logic u,
                            input logic l, input logic [7:0] d);
        if (i < mon_data.size())
            chk($sformatf("%s%0d", tag, i), {mon_grant[i], mon_user[i], mon_last[i], mon_data[i]}, {g, u, l, d});
        else
            chk($sformatf("%s%0d_missing", tag, i), mon_data.size(), i + 1);
    endtask

    initial begin
        logic [1:0] exp_a[6];
        logic [1:0] exp_b[6];
        int c;
        exp_a = '{2'b01, 2'b01, 2'b01, 2'b10, 2'b10, 2'b10};
        exp_b = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};

        // Reset state
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_tx", {a_tx.tvalid, a_tx.tlast, a_tuser}, 3'b000);
        chk("rst_ready", {a_s0.tready, a_s1.tready}, 2'b00);
        chk("rst_grant", a_grant, 2'b00);
        chk("rst_cnt", {a_fc0, a_fc1, a_ab}, 12'h000);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Two back-to-back 64-byte s0 frames with full-rate MAC
        #1;
        clear_mon();
        len[0] = 64; seed[0] = 8'h00; frames_left[0] = 2;
        wait_done("t1_timeout", 600);
        chk("t1_beats", mon_data.size(), 128);
        for (int i = 0; i < 128; i++)
            chk_beat("t1_beat", i, 2'b01, 1'b0, (i == 63) || (i == 127),
                     (i < 64) ? 8'(i) : 8'(8'h40 + i - 64));
        chk("t1_fc0", a_fc0, 2);
        chk("t1_rises", rise_q.size(), 2);
        if (rise_q.size() == 2 && last_q.size() >= 1)
            chk("t1_ifg", rise_q[1] - last_q[0], 14);

        // Contention: priority on dut_a, round-robin on dut_b
        #1;
        clear_mon();
        len[0] = 3; len[1] = 3; len[2] = 3; len[3] = 3;
        frames_left[0] = 3; frames_left[1] = 3; frames_left[2] = 3; frames_left[3] = 3;
        wait_done("t2_timeout", 600);
        chk("t2_ord_a_n", ord_a.size(), 6);
        chk("t2_ord_b_n", ord_b.size(), 6);
        for (int i = 0; i < 6; i++) begin
            if (i < ord_a.size()) chk($sformatf("t2_ord_a%0d", i), ord_a[i], exp_a[i]);
            if (i < ord_b.size()) chk($sformatf("t2_ord_b%0d", i), ord_b[i], exp_b[i]);
        end
        chk("t2_cnt_a", {a_fc0, a_fc1}, {4'd5, 4'd3});
        chk("t2_cnt_b", {b_fc0, b_fc1}, {16'd3, 16'd3});

        // Backpressure on a 256-byte s1 frame, including a 2000-cycle hold
        #1;
        clear_mon();
        len[1] = 256; seed[1] = 8'h80; frames_left[1] = 1; bp_mode = 1;
        c = 0;
        while (mon_data.size() < 100 && c < 1000) begin
            @(negedge clk);
            c++;
        end
        chk("t3_reach100", (c < 1000), 1'b1);
        #1 bp_mode = 2;
        repeat (2000) @(negedge clk);
        chk("t3_no_abort", {a_tx.tvalid, a_tuser, a_grant}, {1'b1, 1'b0, 2'b10});
        #1 bp_mode = 1;
        wait_done("t3_timeout", 1500);
        bp_mode = 0;
        chk("t3_beats", mon_data.size(), 256);
        for (int i = 0; i < 256; i++)
            chk_beat("t3_beat", i, 2'b10, 1'b0, (i == 255), 8'(8'h80 + i));
        chk("t3_abort", a_ab, 0);
        chk("t3_fc1", a_fc1, 4);

        // Stalled s0 frame is truncated, drained, then s1 is served
        #1;
        clear_mon();
        len[0] = 20; seed[0] = 8'h10; pause_at[0] = 10; pause_len[0] = 1100; frames_left[0] = 1;
        len[1] = 5;  seed[1] = 8'hC0; frames_left[1] = 1;
        wait_done("t4_timeout", 3000);
        pause_at[0] = -1;
        chk("t4_beats", mon_data.size(), 16);
        for (int i = 0; i < 10; i++)
            chk_beat("t4_beat", i, 2'b01, 1'b0, 1'b0, 8'(8'h10 + i));
        chk_beat("t4_abort_beat", 10, 2'b01, 1'b1, 1'b1, 8'h00);
        for (int i = 11; i < 16; i++)
            chk_beat("t4_beat", i, 2'b10, 1'b0, (i == 15), 8'(8'hC0 + i - 11));
        chk("t4_cnts", {a_fc0, a_fc1, a_ab}, {4'd5, 4'd5, 4'd1});
        chk("t4_drained", frames_left[0], 0);

        // Reset in the middle of an s1 frame
        #1;
        clear_mon();
        len[1] = 64; seed[1] = 8'h20; frames_left[1] = 1;
        c = 0;
        while (mon_data.size() < 30 && c < 200) begin
            @(negedge clk);
            c++;
        end
        chk("t5_reach30", (c < 200), 1'b1);
        chk("t5_no_tlast", mon_last.sum() with (int'(item)), 0);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_tx", {a_tx.tvalid, a_tx.tlast, a_tuser}, 3'b000);
        chk("t5_ready", {a_s0.tready, a_s1.tready}, 2'b00);
        chk("t5_grant", a_grant, 2'b00);
        chk("t5_cnt", {a_fc0, a_fc1, a_ab}, 12'h000);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // 17 short s1 frames wrap the 4-bit counter to 1
        #1;
        clear_mon();
        len[1] = 4; seed[1] = 8'h50; frames_left[1] = 17;
        wait_done("t6_timeout", 800);
        chk("t6_beats", mon_data.size(), 68);
        for (int i = 0; i < 4; i++)
            chk_beat("t6_beat", i, 2'b10, 1'b0, (i == 3), 8'(8'h50 + i));
        chk("t6_cnts", {a_fc0, a_fc1, a_ab}, {4'd0, 4'd1, 4'd0});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
